// File: rtl/ldpc_out_ctrl.sv
// -----------------------------------------------------------------------------
// ldpc_out_ctrl
//
// Output-phase sequencer for the LDPC decoder. Once decoding finishes, this
// block walks the output-table addresses 0..N-1 once per codeword. N is 4608
// or 6912 and is chosen by the rate that is latched at start. It collects the
// returned hard-decision bits, packs them MSB-first into bytes, and buffers
// those bytes in a small FIFO that feeds a valid/ready byte interface.
//
// An address is issued only when every bit already in flight, plus the new
// one, is sure to fit in the FIFO. A downstream stall therefore never drops
// or overwrites data.
//
// Ports
//   clk         in   1   clock
//   reset       in   1   async reset, active high
//   start       in   1   one-cycle pulse: begin output phase (IDLE only)
//   rate        in   1   code rate select, sampled on accepted start
//   busy        out  1   high in RUN and DRAIN
//   done        out  1   one-cycle pulse after the final byte handshake
//   tbl_en      out  1   address issue strobe
//   tbl_addr    out  13  bit index being issued (valid with tbl_en)
//   hd_bit      in   1   hard bit for the address issued LAT cycles earlier
//   dout        out  8   packed byte, first-issued bit in dout[7]
//   dout_valid  out  1   byte available at FIFO head
//   dout_ready  in   1   downstream accept
//   dout_last   out  1   head byte is the final byte of the codeword
// -----------------------------------------------------------------------------
module ldpc_out_ctrl #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int N_R0  = 4608,
  parameter int N_R1  = 6912
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rate,
  output logic        busy,
  output logic        done,
  output logic        tbl_en,
  output logic [12:0] tbl_addr,
  input  logic        hd_bit,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int IW = $clog2(LAT + 1);
  localparam int OW = $clog2(8 * DEPTH + 8 + LAT) + 1;
  localparam logic [OW-1:0] OCC_MAX = OW'(8 * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [12:0]   n_bits;
  logic [12:0]   issue_cnt;
  logic [LAT-1:0] vld_sr;
  logic          bit_vld;
  logic [IW-1:0] inflight;
  logic [2:0]    pack_cnt;
  logic [6:0]    pack_reg;
  logic [9:0]    byte_idx;
  logic [9:0]    last_idx;

  logic [7:0]    mem_data [DEPTH];
  logic          mem_last [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic          push;
  logic          pop;
  logic          push_last;
  logic [7:0]    push_byte;
  logic [OW-1:0] occ;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic.
  // RUN stays one extra cycle after the last issue, so DRAIN is entered only
  // once issue_cnt has been seen equal to n_bits. DRAIN ends on the handshake
  // of the byte tagged last, so done follows that handshake by one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue_cnt >= n_bits) state_next = DRAIN;
      DRAIN:   if (pop && dout_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs.
  // occ counts every bit the FIFO may eventually have to hold. Each bit is
  // counted exactly once: while in flight, then in the pack register, then in
  // the FIFO. Issuing only while occ is below the FIFO capacity in bits means
  // a push can never meet a full FIFO.
  // ---------------------------------------------------------------------------
  always_comb begin
    occ    = (OW'(fifo_cnt) << 3) + OW'(pack_cnt) + OW'(inflight);
    busy   = (state == RUN) || (state == DRAIN);
    done   = (state == DONE);
    tbl_en = (state == RUN) && (issue_cnt < n_bits) && (occ < OCC_MAX);
  end

  assign tbl_addr = issue_cnt;

  // ---------------------------------------------------------------------------
  // Codeword length latch and issue counter. rate only matters on an accepted
  // start. Toggling rate later has no effect on the running codeword.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_bits    <= '0;
      issue_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      n_bits    <= rate ? 13'(N_R1) : 13'(N_R0);
      issue_cnt <= '0;
    end else if (tbl_en) begin
      issue_cnt <= issue_cnt + 13'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Return-path alignment. tbl_en is delayed LAT cycles to mark the cycle in
  // which hd_bit belongs to a real issued address. inflight mirrors how many
  // marks are currently travelling through the delay line.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr   <= '0;
      inflight <= '0;
    end else begin
      vld_sr[0] <= tbl_en;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
      inflight <= inflight + IW'(tbl_en) - IW'(bit_vld);
    end
  end

  assign bit_vld = vld_sr[LAT-1];

  // ---------------------------------------------------------------------------
  // Bit packing. Only seven bits are stored. The eighth goes straight into the
  // pushed byte, and pack_cnt wraps to zero in the same cycle.
  // ---------------------------------------------------------------------------
  assign push      = bit_vld && (pack_cnt == 3'd7);
  assign push_byte = {pack_reg, hd_bit};
  assign last_idx  = n_bits[12:3] - 10'd1;
  assign push_last = (byte_idx == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack_reg <= '0;
      pack_cnt <= '0;
      byte_idx <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        byte_idx <= '0;
      end else if (push) begin
        byte_idx <= byte_idx + 10'd1;
      end
      if (bit_vld) begin
        pack_reg <= {pack_reg[5:0], hd_bit};
        pack_cnt <= pack_cnt + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO. The last flag travels with its byte, so dout_last holds until
  // that byte is popped. A push and a pop in the same cycle leave the count
  // unchanged.
  // ---------------------------------------------------------------------------
  assign dout_valid = (fifo_cnt != '0);
  assign pop        = dout_valid && dout_ready;
  assign dout       = mem_data[rd_ptr];
  assign dout_last  = dout_valid && mem_last[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_byte;
        mem_last[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
